// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- shared definitions for the pattern sequencer.
//
// Contents:
//   state_e             sequencer FSM states
//   AWIDTH_DEF          default pattern-memory address width
//   NPAT_DEF            default number of patterns per epoch
//   EWIDTH_DEF          default epoch counter width
//   FX_FRAC_BITS/FX_ONE Q6.10 fixed-point constants used by the datapath
//   fx_from_int         helper converting a small integer to Q6.10
// -----------------------------------------------------------------------------
package seq_pkg;

   localparam int AWIDTH_DEF = 4;
   localparam int NPAT_DEF   = 4;
   localparam int EWIDTH_DEF = 16;

   // Q6.10: 6 integer bits, 10 fractional bits.
   localparam int          FX_FRAC_BITS = 10;
   localparam logic [15:0] FX_ONE       = 16'h0400;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_PRESENT = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   function automatic logic [15:0] fx_from_int(input logic [5:0] val);
      return {val, {FX_FRAC_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter -- modulo-MODULUS up counter used as the pattern address.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (count -> 0)
//   clr_i    synchronous clear to 0 (has priority over inc_i)
//   inc_i    advance by one; wraps to 0 from MODULUS-1
//   count_o  current count (registered)
//   wrap_o   count is at MODULUS-1, i.e. the next increment wraps
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign wrap_o  = (count_q == LAST);
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = wrap_o ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pattern_seq.sv
// -----------------------------------------------------------------------------
// pattern_seq -- steps a pattern memory through NPAT patterns per epoch for
// epoch_max epochs, handing each pattern to a datapath and waiting for ack.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   abort      (only with SEQ_ABORT_EN) end the run early with a done pulse
//   start      begin a run (sampled in IDLE only)
//   epoch_max  epochs to run, sampled with start
//   ack        datapath consumed the current pattern (sampled in PRESENT only)
//   addr       pattern index to the memories
//   din        memory read enable
//   valid      memory outputs are stable for addr
//   last       valid and addr is NPAT-1
//   epoch_cnt  completed epochs
//   busy       not IDLE
//   done       one-cycle pulse at end of run
//
// Handshake: a pattern is presented while valid=1; it is consumed on the
// rising edge where valid=1 and ack=1. ack at any other time has no effect.
//
// Build option: define SEQ_ABORT_EN to add the abort input.
//
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output without passing through a register.
// -----------------------------------------------------------------------------
module pattern_seq
   import seq_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int NPAT   = NPAT_DEF,
   parameter int EWIDTH = EWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SEQ_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [EWIDTH-1:0] epoch_max,
   input  logic              ack,
   output logic [AWIDTH-1:0] addr,
   output logic              din,
   output logic              valid,
   output logic              last,
   output logic [EWIDTH-1:0] epoch_cnt,
   output logic              busy,
   output logic              done
);

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NPAT - 1);

   state_e            state_q, state_d;
   logic [EWIDTH-1:0] epoch_max_q, epoch_max_d;
   logic [EWIDTH-1:0] epoch_cnt_q, epoch_cnt_d;
   logic              din_q, valid_q, last_q, busy_q, done_q;
   logic              cnt_clr, cnt_inc, cnt_wrap;
   logic [AWIDTH-1:0] cnt_val;

   mod_counter #(
      .WIDTH   (AWIDTH),
      .MODULUS (NPAT)
   ) u_addr_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .count_o (cnt_val),
      .wrap_o  (cnt_wrap)
   );

   always_comb begin
      state_d     = state_q;
      epoch_max_d = epoch_max_q;
      epoch_cnt_d = epoch_cnt_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clr     = 1'b1;
               epoch_cnt_d = '0;
               if (epoch_max == '0) begin
                  state_d = ST_DONE;
               end else begin
                  epoch_max_d = epoch_max;
                  state_d     = ST_FETCH;
               end
            end
         end
         // One cycle of memory read latency before the data is usable.
         ST_FETCH: state_d = ST_PRESENT;
         ST_PRESENT: begin
            if (ack) begin
               state_d = ST_ADVANCE;
            end
         end
         ST_ADVANCE: begin
            cnt_inc = 1'b1;
            state_d = ST_FETCH;
            if (cnt_wrap) begin
               epoch_cnt_d = epoch_cnt_q + EWIDTH'(1);
               // Compare against the incremented count: the epoch just
               // finished is the one that may end the run.
               if (epoch_cnt_d == epoch_max_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

`ifdef SEQ_ABORT_EN
      // Abort freezes address and epoch count where they are. DONE itself
      // is excluded so an abort held high cannot stretch the done pulse.
      if (abort && (state_q == ST_FETCH || state_q == ST_PRESENT ||
                    state_q == ST_ADVANCE)) begin
         state_d     = ST_DONE;
         cnt_inc     = 1'b0;
         epoch_cnt_d = epoch_cnt_q;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         epoch_max_q <= '0;
         epoch_cnt_q <= '0;
         din_q       <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         epoch_max_q <= epoch_max_d;
         epoch_cnt_q <= epoch_cnt_d;
         din_q       <= (state_d == ST_FETCH) || (state_d == ST_PRESENT);
         valid_q     <= (state_d == ST_PRESENT);
         // Entering or staying in PRESENT never moves the counter, so the
         // current count is also the count seen alongside valid.
         last_q      <= (state_d == ST_PRESENT) && (cnt_val == LAST_ADDR);
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   assign addr      = cnt_val;
   assign epoch_cnt = epoch_cnt_q;
   assign din       = din_q;
   assign valid     = valid_q;
   assign last      = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pattern_seq.sv
// -----------------------------------------------------------------------------
// tb_pattern_seq -- bench for pattern_seq (default parameters).
// Each run is described as a list of patterns (epoch, addr, hold cycles);
// the expected per-cycle output trace is expanded from that list and
// compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_pattern_seq;

   localparam int AW   = 4;
   localparam int NP   = 4;
   localparam int EW   = 16;
   localparam int VW   = 5 + AW + EW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [EW-1:0] epoch_max;
   logic          ack;
   logic [AW-1:0] addr;
   logic          din, valid, last, busy, done;
   logic [EW-1:0] epoch_cnt;
`ifdef SEQ_ABORT_EN
   logic          abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [VW-1:0] exp_q[$];
   logic          ack_q[$];
   int            hold_a[64];

   pattern_seq #(.AWIDTH(AW), .NPAT(NP), .EWIDTH(EW)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SEQ_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .epoch_max (epoch_max),
      .ack       (ack),
      .addr      (addr),
      .din       (din),
      .valid     (valid),
      .last      (last),
      .epoch_cnt (epoch_cnt),
      .busy      (busy),
      .done      (done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // {busy, done, din, valid, last, addr, epoch_cnt}
   function automatic logic [VW-1:0] mk(input logic b, input logic d, input logic di,
                                        input logic v, input logic l, input int a, input int e);
      return {b, d, di, v, l, AW'(a), EW'(e)};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {busy, done, din, valid, last, addr, epoch_cnt};
   endfunction

   // ---------------- driver / model ----------------
   // Runs one training run of emax epochs using hold_a[k] extra PRESENT
   // cycles for pattern k. ack is noise outside PRESENT (all-ones when
   // noise_hi). stop_at >= 0 returns right after checking that trace entry.
   task automatic run_seq(input string tag, input int emax, input bit noise_hi,
                          input int stop_at, input int abort_at);
      int k;
      logic [VW-1:0] last_vec;
      exp_q.delete();
      ack_q.delete();
      k = 0;
      for (int e = 0; e < emax; e++) begin
         for (int a = 0; a < NP; a++) begin
            exp_q.push_back(mk(1, 0, 1, 0, 0, a, e));
            ack_q.push_back(noise_hi ? 1'b1 : 1'($urandom_range(0, 1)));
            for (int j = 0; j <= hold_a[k]; j++) begin
               exp_q.push_back(mk(1, 0, 1, 1, a == NP - 1, a, e));
               ack_q.push_back(j == hold_a[k]);
            end
            exp_q.push_back(mk(1, 0, 0, 0, 0, a, e));
            ack_q.push_back(noise_hi ? 1'b1 : 1'($urandom_range(0, 1)));
            k++;
         end
      end
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, emax));
      ack_q.push_back(1'b0);
`ifdef SEQ_ABORT_EN
      // Abort: DONE follows the aborted cycle with addr/epoch frozen.
      if (abort_at >= 0 && abort_at < exp_q.size() - 1) begin
         last_vec = exp_q[abort_at];
         while (exp_q.size() > abort_at + 1) begin
            void'(exp_q.pop_back());
            void'(ack_q.pop_back());
         end
         exp_q.push_back(mk(1, 1, 0, 0, 0, int'(last_vec[EW+AW-1:EW]), int'(last_vec[EW-1:0])));
         ack_q.push_back(1'b0);
      end
`endif

      @(negedge clk);
      start     = 1'b1;
      epoch_max = EW'(emax);
      ack       = noise_hi ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check($sformatf("%s cyc%0d", tag, i), 32'(dut_vec()), 32'(exp_q[i]));
         if (i == stop_at) return;
         ack       = ack_q[i];
         start     = 1'($urandom_range(0, 1));   // ignored while busy
         epoch_max = EW'($urandom);               // ignored mid-run
`ifdef SEQ_ABORT_EN
         abort     = (i == abort_at);
`endif
      end
      last_vec = exp_q[exp_q.size() - 1];
      last_vec[VW-1] = 1'b0;
      last_vec[VW-2] = 1'b0;
      @(negedge clk);
      check({tag, " idle"}, 32'(dut_vec()), 32'(last_vec));
      start     = 1'b0;
      ack       = 1'b0;
      epoch_max = '0;
`ifdef SEQ_ABORT_EN
      abort     = 1'b0;
`endif
   endtask

   task automatic set_holds(input int hmax);
      for (int i = 0; i < 64; i++) hold_a[i] = $urandom_range(0, hmax);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      ack       = 1'b0;
      epoch_max = '0;
      #1;
      check("reset", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ack high throughout, 2 epochs: done lands 24 cycles after start edge.
      set_holds(0);
      run_seq("basic", 2, 1'b1, -1, -1);

      // epoch_max = 0: straight to DONE, din never asserted.
      run_seq("zero", 0, 1'b1, -1, -1);

      // ack withheld: 5 PRESENT cycles at addr 2, ack high during FETCH.
      set_holds(0);
      hold_a[2] = 4;
      run_seq("hold", 1, 1'b1, -1, -1);

      // Reset in PRESENT of epoch 1, addr 1 (pattern 5 -> entry 16).
      set_holds(0);
      run_seq("rstmid", 2, 1'b1, 16, -1);
      #2 rst = 1'b1;
      #1 check("rst async", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
      start = 1'b0;
      ack   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post rst", 32'(dut_vec()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
      end
      set_holds(2);
      run_seq("restart", 1, 1'b0, -1, -1);

`ifdef SEQ_ABORT_EN
      // Abort in FETCH of addr 1, epoch 0 (entry 3 with zero holds).
      set_holds(0);
      run_seq("abort", 2, 1'b1, -1, 3);
`endif

      // Randomized runs: random holds, ack noise, start/epoch_max noise.
      for (int r = 0; r < 12; r++) begin
         set_holds(3);
         run_seq($sformatf("rnd%0d", r), $urandom_range(0, 3), 1'b0, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
